// File: rtl/sha_state_accum.sv
// rtl/sha_state_accum.sv - SHA-256 chaining-state accumulator with single/double pass control
module sha_state_accum #(
    parameter int                       WORDS = 8,
    parameter int                       WIDTH = 32,
    parameter logic [WORDS*WIDTH-1:0]   IV    = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19,
    parameter int                       CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    mode_double,
    input  logic                    abort,
    input  logic                    wv_valid,
    input  logic                    wv_last,
    input  logic [WORDS*WIDTH-1:0]  wv_in,
    output logic                    wv_ready,
    output logic                    mid_valid,
    output logic [WORDS*WIDTH-1:0]  mid_out,
    output logic                    digest_valid,
    output logic [WORDS*WIDTH-1:0]  digest_out,
    input  logic                    digest_ack,
    output logic [CNT_W-1:0]        blk_cnt,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS1 = 2'd1,
        ST_PASS2 = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [WORDS*WIDTH-1:0]   h_q, h_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     dbl_q, dbl_d;
    logic [WORDS*WIDTH-1:0]   mid_q, mid_d;
    logic                     mid_valid_q, mid_valid_d;
    logic [WORDS*WIDTH-1:0]   dig_q, dig_d;
    logic                     dig_valid_q, dig_valid_d;

    logic [WORDS*WIDTH-1:0]   sum;
    logic [CNT_W-1:0]         cnt_inc;
    logic                     accum;

    // Word-wise modulo-2^WIDTH sum of the chaining state and the working variables.
    always_comb begin
        sum = '0;
        for (int i = 0; i < WORDS; i++) begin
            sum[i*WIDTH +: WIDTH] = h_q[i*WIDTH +: WIDTH] + wv_in[i*WIDTH +: WIDTH];
        end
    end

    assign cnt_inc  = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
    assign wv_ready = (state_q == ST_PASS1) || (state_q == ST_PASS2);
    assign accum    = wv_ready && wv_valid;

    // Next-state logic: abort overrides everything; a last block closes the pass.
    always_comb begin
        state_d     = state_q;
        h_d         = h_q;
        cnt_d       = cnt_q;
        dbl_d       = dbl_q;
        mid_d       = mid_q;
        mid_valid_d = 1'b0;
        dig_d       = dig_q;
        dig_valid_d = dig_valid_q;

        if (abort) begin
            state_d     = ST_IDLE;
            h_d         = IV;
            cnt_d       = '0;
            dig_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = ST_PASS1;
                        h_d     = IV;
                        cnt_d   = '0;
                        dbl_d   = mode_double;
                    end
                end
                ST_PASS1, ST_PASS2: begin
                    if (accum) begin
                        h_d   = sum;
                        cnt_d = cnt_inc;
                        if (wv_last) begin
                            if ((state_q == ST_PASS1) && dbl_q) begin
                                // First-pass digest becomes the second-pass message.
                                mid_d       = sum;
                                mid_valid_d = 1'b1;
                                h_d         = IV;
                                cnt_d       = '0;
                                state_d     = ST_PASS2;
                            end else begin
                                dig_d       = sum;
                                dig_valid_d = 1'b1;
                                state_d     = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (digest_ack) begin
                        dig_valid_d = 1'b0;
                        if (start) begin
                            state_d = ST_PASS1;
                            h_d     = IV;
                            cnt_d   = '0;
                            dbl_d   = mode_double;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            h_q         <= IV;
            cnt_q       <= '0;
            dbl_q       <= 1'b0;
            mid_q       <= '0;
            mid_valid_q <= 1'b0;
            dig_q       <= '0;
            dig_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            h_q         <= h_d;
            cnt_q       <= cnt_d;
            dbl_q       <= dbl_d;
            mid_q       <= mid_d;
            mid_valid_q <= mid_valid_d;
            dig_q       <= dig_d;
            dig_valid_q <= dig_valid_d;
        end
    end

    assign mid_valid    = mid_valid_q;
    assign mid_out      = mid_q;
    assign digest_valid = dig_valid_q;
    assign digest_out   = dig_q;
    assign blk_cnt      = cnt_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sha_state_accum.sv
// tb/tb_sha_state_accum.sv - directed self-checking bench for sha_state_accum
module tb_sha_state_accum;

    localparam logic [255:0] IV = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         mode_double;
    logic         abort;
    logic         wv_valid;
    logic         wv_last;
    logic [255:0] wv_in;
    logic         wv_ready;
    logic         mid_valid;
    logic [255:0] mid_out;
    logic         digest_valid;
    logic [255:0] digest_out;
    logic         digest_ack;
    logic [7:0]   blk_cnt;
    logic         busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    sha_state_accum dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .mode_double  (mode_double),
        .abort        (abort),
        .wv_valid     (wv_valid),
        .wv_last      (wv_last),
        .wv_in        (wv_in),
        .wv_ready     (wv_ready),
        .mid_valid    (mid_valid),
        .mid_out      (mid_out),
        .digest_valid (digest_valid),
        .digest_out   (digest_out),
        .digest_ack   (digest_ack),
        .blk_cnt      (blk_cnt),
        .busy         (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic dbl);
        start       = 1'b1;
        mode_double = dbl;
        tick();
        start       = 1'b0;
        mode_double = 1'b0;
    endtask

    task automatic send_block(input logic [255:0] w, input logic last);
        wv_valid = 1'b1;
        wv_last  = last;
        wv_in    = w;
        tick();
        wv_valid = 1'b0;
        wv_last  = 1'b0;
        wv_in    = '0;
    endtask

    task automatic do_ack();
        digest_ack = 1'b1;
        tick();
        digest_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++; if (wv_ready !== 1'b0) $display("FAIL reset_wv_ready got %b want 0", wv_ready); else pass_cnt++;
        total_cnt++; if (digest_valid !== 1'b0 || mid_valid !== 1'b0) $display("FAIL reset_valids got %b%b want 00", digest_valid, mid_valid); else pass_cnt++;
        total_cnt++; if (digest_out !== 256'h0 || mid_out !== 256'h0) $display("FAIL reset_data got %h / %h want 0", digest_out, mid_out); else pass_cnt++;
        total_cnt++; if (blk_cnt !== 8'd0) $display("FAIL reset_blk_cnt got %0d want 0", blk_cnt); else pass_cnt++;
        // wv_valid in IDLE is ignored
        send_block(256'h1, 1'b1);
        total_cnt++; if (digest_valid !== 1'b0 || blk_cnt !== 8'd0 || busy !== 1'b0) $display("FAIL idle_wv_ignored got dv=%b cnt=%0d busy=%b want 0/0/0", digest_valid, blk_cnt, busy); else pass_cnt++;
    endtask

    task automatic test_single_zero();
        do_start(1'b0);
        total_cnt++; if (busy !== 1'b1 || wv_ready !== 1'b1) $display("FAIL single_start got busy=%b rdy=%b want 1/1", busy, wv_ready); else pass_cnt++;
        send_block(256'h0, 1'b1);
        total_cnt++; if (digest_valid !== 1'b1) $display("FAIL single_dv got %b want 1", digest_valid); else pass_cnt++;
        total_cnt++; if (digest_out !== IV) $display("FAIL single_digest got %h want %h", digest_out, IV); else pass_cnt++;
        total_cnt++; if (blk_cnt !== 8'd1) $display("FAIL single_blk_cnt got %0d want 1", blk_cnt); else pass_cnt++;
        total_cnt++; if (mid_valid !== 1'b0) $display("FAIL single_no_mid got %b want 0", mid_valid); else pass_cnt++;
        do_ack();
        total_cnt++; if (digest_valid !== 1'b0 || busy !== 1'b0) $display("FAIL single_ack got dv=%b busy=%b want 0/0", digest_valid, busy); else pass_cnt++;
    endtask

    task automatic test_wrap();
        do_start(1'b0);
        send_block({224'h0, 32'hFFFFFFFF}, 1'b1);
        total_cnt++; if (digest_out[31:0] !== 32'h5be0cd18) $display("FAIL wrap_word7 got %h want 5be0cd18", digest_out[31:0]); else pass_cnt++;
        total_cnt++; if (digest_out[63:32] !== 32'h1f83d9ab) $display("FAIL wrap_word6 got %h want 1f83d9ab", digest_out[63:32]); else pass_cnt++;
        do_ack();
    endtask

    task automatic test_two_block();
        do_start(1'b0);
        send_block({32'h1, 224'h0}, 1'b0);
        total_cnt++; if (blk_cnt !== 8'd1 || digest_valid !== 1'b0) $display("FAIL two_mid got cnt=%0d dv=%b want 1/0", blk_cnt, digest_valid); else pass_cnt++;
        send_block({32'h1, 224'h0}, 1'b1);
        total_cnt++; if (digest_out[255:224] !== 32'h6a09e669) $display("FAIL two_word0 got %h want 6a09e669", digest_out[255:224]); else pass_cnt++;
        total_cnt++; if (blk_cnt !== 8'd2) $display("FAIL two_blk_cnt got %0d want 2", blk_cnt); else pass_cnt++;
        total_cnt++; if (wv_ready !== 1'b0) $display("FAIL two_done_ready got %b want 0", wv_ready); else pass_cnt++;
        // start in DONE without ack is ignored
        do_start(1'b1);
        total_cnt++; if (digest_valid !== 1'b1 || digest_out[255:224] !== 32'h6a09e669 || wv_ready !== 1'b0) $display("FAIL done_start_ignored got dv=%b w0=%h rdy=%b want 1/6a09e669/0", digest_valid, digest_out[255:224], wv_ready); else pass_cnt++;
        do_ack();
    endtask

    task automatic test_double();
        do_start(1'b1);
        send_block(256'h0, 1'b1);
        total_cnt++; if (mid_valid !== 1'b1) $display("FAIL dbl_mid_valid got %b want 1", mid_valid); else pass_cnt++;
        total_cnt++; if (mid_out !== IV) $display("FAIL dbl_mid_out got %h want %h", mid_out, IV); else pass_cnt++;
        total_cnt++; if (blk_cnt !== 8'd0 || digest_valid !== 1'b0 || wv_ready !== 1'b1) $display("FAIL dbl_pass2_entry got cnt=%0d dv=%b rdy=%b want 0/0/1", blk_cnt, digest_valid, wv_ready); else pass_cnt++;
        tick();
        total_cnt++; if (mid_valid !== 1'b0 || mid_out !== IV) $display("FAIL dbl_mid_pulse got mv=%b mid=%h want 0/IV", mid_valid, mid_out); else pass_cnt++;
        send_block({32'h1, 224'h0}, 1'b1);
        total_cnt++; if (digest_out !== {32'h6a09e668, IV[223:0]}) $display("FAIL dbl_digest got %h want %h", digest_out, {32'h6a09e668, IV[223:0]}); else pass_cnt++;
        total_cnt++; if (blk_cnt !== 8'd1) $display("FAIL dbl_blk_cnt got %0d want 1", blk_cnt); else pass_cnt++;
        tick(); tick(); tick();
        total_cnt++; if (digest_valid !== 1'b1 || digest_out[255:224] !== 32'h6a09e668) $display("FAIL dbl_hold got dv=%b w0=%h want 1/6a09e668", digest_valid, digest_out[255:224]); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        // ack and start together from DONE left by test_double
        digest_ack  = 1'b1;
        start       = 1'b1;
        mode_double = 1'b0;
        tick();
        digest_ack  = 1'b0;
        start       = 1'b0;
        total_cnt++; if (digest_valid !== 1'b0 || busy !== 1'b1 || wv_ready !== 1'b1 || blk_cnt !== 8'd0) $display("FAIL b2b_accept got dv=%b busy=%b rdy=%b cnt=%0d want 0/1/1/0", digest_valid, busy, wv_ready, blk_cnt); else pass_cnt++;
        send_block({32'h3, 224'h0}, 1'b1);
        total_cnt++; if (digest_valid !== 1'b1 || digest_out[255:224] !== 32'h6a09e66a || mid_valid !== 1'b0) $display("FAIL b2b_digest got dv=%b w0=%h mv=%b want 1/6a09e66a/0", digest_valid, digest_out[255:224], mid_valid); else pass_cnt++;
        do_ack();
    endtask

    task automatic test_abort();
        do_start(1'b1);
        send_block(256'h0, 1'b1);
        abort    = 1'b1;
        wv_valid = 1'b1;
        wv_last  = 1'b1;
        wv_in    = {32'h5, 224'h0};
        tick();
        abort    = 1'b0;
        wv_valid = 1'b0;
        wv_last  = 1'b0;
        wv_in    = '0;
        total_cnt++; if (busy !== 1'b0 || digest_valid !== 1'b0 || blk_cnt !== 8'd0) $display("FAIL abort_state got busy=%b dv=%b cnt=%0d want 0/0/0", busy, digest_valid, blk_cnt); else pass_cnt++;
        total_cnt++; if (digest_out[255:224] !== 32'h6a09e66a || mid_out !== IV) $display("FAIL abort_keep got d0=%h mid=%h want 6a09e66a/IV", digest_out[255:224], mid_out); else pass_cnt++;
        do_start(1'b0);
        send_block({32'h2, 224'h0}, 1'b1);
        total_cnt++; if (digest_out !== {32'h6a09e669, IV[223:0]} || blk_cnt !== 8'd1) $display("FAIL abort_fresh got %h cnt=%0d want %h cnt=1", digest_out, blk_cnt, {32'h6a09e669, IV[223:0]}); else pass_cnt++;
        do_ack();
    endtask

    task automatic test_reset_mid();
        do_start(1'b0);
        send_block({32'h1, 224'h0}, 1'b0);
        total_cnt++; if (blk_cnt !== 8'd1 || busy !== 1'b1) $display("FAIL rmid_pre got cnt=%0d busy=%b want 1/1", blk_cnt, busy); else pass_cnt++;
        rst_n = 1'b0;
        start = 1'b1;
        tick();
        rst_n = 1'b1;
        start = 1'b0;
        total_cnt++; if (busy !== 1'b0 || wv_ready !== 1'b0 || blk_cnt !== 8'd0) $display("FAIL rmid_state got busy=%b rdy=%b cnt=%0d want 0/0/0", busy, wv_ready, blk_cnt); else pass_cnt++;
        total_cnt++; if (digest_out !== 256'h0 || mid_out !== 256'h0 || digest_valid !== 1'b0 || mid_valid !== 1'b0) $display("FAIL rmid_outputs got d=%h m=%h dv=%b mv=%b want zeros", digest_out, mid_out, digest_valid, mid_valid); else pass_cnt++;
        tick();
        total_cnt++; if (busy !== 1'b0) $display("FAIL rmid_start_ignored got busy=%b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_saturation();
        do_start(1'b0);
        for (int i = 0; i < 256; i++) begin
            send_block(256'h0, 1'b0);
        end
        total_cnt++; if (blk_cnt !== 8'hFF) $display("FAIL sat_cnt got %0d want 255", blk_cnt); else pass_cnt++;
        send_block({32'h1, 224'h0}, 1'b1);
        total_cnt++; if (blk_cnt !== 8'hFF || digest_out[255:224] !== 32'h6a09e668 || digest_valid !== 1'b1) $display("FAIL sat_final got cnt=%0d w0=%h dv=%b want 255/6a09e668/1", blk_cnt, digest_out[255:224], digest_valid); else pass_cnt++;
        do_ack();
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        mode_double = 1'b0;
        abort       = 1'b0;
        wv_valid    = 1'b0;
        wv_last     = 1'b0;
        wv_in       = '0;
        digest_ack  = 1'b0;
        #1;
        test_reset();
        test_single_zero();
        test_wrap();
        test_two_block();
        test_double();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_saturation();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
